// File: rtl/adder_sched_if.sv
// rtl/adder_sched_if.sv - requester/result bus for adder_sched
// Two request streams in, one registered result stream out.
interface adder_sched_if #(
   parameter int N = 32
);
   logic         req0_valid;
   logic         req0_ready;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic         req0_sub;
   logic         req0_last;

   logic         req1_valid;
   logic         req1_ready;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;
   logic         req1_sub;
   logic         req1_last;

   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_id;
   logic         out_last;
   logic         out_cout;
   logic         out_ovf;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub, req0_last,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sub, req1_last,
      input  req1_ready,
      input  out_valid, out_sum, out_id, out_last, out_cout, out_ovf,
      output out_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub, req0_last,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sub, req1_last,
      output req1_ready,
      output out_valid, out_sum, out_id, out_last, out_cout, out_ovf,
      input  out_ready
   );
endinterface

// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - two-requester round-robin scheduler around one N-bit adder
// Optional subtract support is enabled by defining ADDER_SCHED_SUB_EN.
module adder_n #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);
   logic [N-1:0] w_g;
   logic [N-1:0] w_p;
   logic [N:0]   w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Generate/propagate lookahead recurrence; synthesis flattens it into a prefix tree.
   always_comb begin
      w_c    = '0;
      w_c[0] = i_cin;
      for (int i = 0; i < N; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
   end

   assign o_sum  = w_p ^ w_c[N-1:0];
   assign o_cout = w_c[N];
endmodule

module adder_sched #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   adder_sched_if.slave io_bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic         r_rr_ptr;
   logic         r_carry;

   logic         r_out_valid;
   logic [N-1:0] r_out_sum;
   logic         r_out_id;
   logic         r_out_last;
   logic         r_out_cout;
   logic         r_out_ovf;

   logic         w_slot_free;
   logic         w_gnt;
   logic         w_gnt_id;
   logic         w_first;
   logic         w_acc;
   logic         w_sel_valid;
   logic         w_sel_last;
   logic [N-1:0] w_sel_a;
   logic [N-1:0] w_sel_b;
   logic         w_sub_eff;
   logic         w_cin;
   logic [N-1:0] w_b_eff;
   logic [N-1:0] w_sum;
   logic         w_cout;
   logic         w_ovf;

   assign w_slot_free = !r_out_valid || io_bus.out_ready;
   assign w_first     = (r_state == S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 1'b0;
      w_gnt_id    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.req0_valid && io_bus.req1_valid) begin
               w_gnt    = 1'b1;
               w_gnt_id = r_rr_ptr;
            end else if (io_bus.req0_valid) begin
               w_gnt    = 1'b1;
               w_gnt_id = 1'b0;
            end else if (io_bus.req1_valid) begin
               w_gnt    = 1'b1;
               w_gnt_id = 1'b1;
            end
         end
         S_LOCK0: begin
            w_gnt    = 1'b1;
            w_gnt_id = 1'b0;
         end
         S_LOCK1: begin
            w_gnt    = 1'b1;
            w_gnt_id = 1'b1;
         end
         default: begin
            w_gnt = 1'b0;
         end
      endcase

      w_sel_valid = w_gnt_id ? io_bus.req1_valid : io_bus.req0_valid;
      w_sel_last  = w_gnt_id ? io_bus.req1_last  : io_bus.req0_last;
      w_sel_a     = w_gnt_id ? io_bus.req1_a     : io_bus.req0_a;
      w_sel_b     = w_gnt_id ? io_bus.req1_b     : io_bus.req0_b;
      w_acc       = w_gnt && w_slot_free && w_sel_valid;

      if (w_acc) begin
         w_state_nxt = w_sel_last ? S_IDLE : (w_gnt_id ? S_LOCK1 : S_LOCK0);
      end
   end

   assign io_bus.req0_ready = w_gnt && !w_gnt_id && w_slot_free;
   assign io_bus.req1_ready = w_gnt &&  w_gnt_id && w_slot_free;

`ifdef ADDER_SCHED_SUB_EN
   logic r_sub_q;
   logic w_sel_sub;

   assign w_sel_sub = w_gnt_id ? io_bus.req1_sub : io_bus.req0_sub;
   assign w_sub_eff = w_first ? w_sel_sub : r_sub_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sub_q <= 1'b0;
      end else if (w_acc && w_first) begin
         r_sub_q <= w_sub_eff;
      end
   end
`else
   logic w_unused_sub;

   assign w_unused_sub = io_bus.req0_sub ^ io_bus.req1_sub;
   assign w_sub_eff    = 1'b0;
`endif

   assign w_cin   = w_first ? w_sub_eff : r_carry;
   assign w_b_eff = w_sel_b ^ {N{w_sub_eff}};
   assign w_ovf   = (w_sel_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != w_sel_a[N-1]);

   adder_n #(.N(N)) u_adder (
      .i_a    (w_sel_a),
      .i_b    (w_b_eff),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= 1'b0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_id    <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_cout  <= 1'b0;
         r_out_ovf   <= 1'b0;
      end else begin
         if (w_acc) begin
            if (w_sel_last) begin
               r_rr_ptr <= ~w_gnt_id;
               r_carry  <= 1'b0;
            end else begin
               r_carry  <= w_cout;
            end
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_id    <= w_gnt_id;
            r_out_last  <= w_sel_last;
            r_out_cout  <= w_cout;
            r_out_ovf   <= w_ovf;
         end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_sum   = r_out_sum;
   assign io_bus.out_id    = r_out_id;
   assign io_bus.out_last  = r_out_last;
   assign io_bus.out_cout  = r_out_cout;
   assign io_bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_adder_sched.sv
// tb/tb_adder_sched.sv - directed vector bench for adder_sched
// Subtract vectors are included when ADDER_SCHED_SUB_EN is defined.
module tb_adder_sched;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   adder_sched_if #(.N(32)) bus ();

   adder_sched #(.N(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        last;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic id, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic sub, input logic last);
      if (id) begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
         bus.req1_sub = sub; bus.req1_last = last;
      end else begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
         bus.req0_sub = sub; bus.req0_last = last;
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send_word(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic last);
      logic got;
      got = 1'b0;
      drive_req(id, 1'b1, a, b, sub, last);
      for (int t = 0; t < 20 && !got; t++) begin
         #1;
         if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
         else @(negedge clk);
      end
      if (got) begin
         @(posedge clk);
         @(negedge clk);
      end else begin
         chk("ready_timeout", {31'b0, got}, 32'd1);
      end
      drive_req(id, 1'b0, a, b, sub, last);
   endtask

   task automatic check_out(input string name, input logic id, input logic [31:0] sum,
                            input logic cout, input logic last, input logic ovf);
      chk({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      chk({name, "_sum"},   bus.out_sum, sum);
      chk({name, "_id"},    {31'b0, bus.out_id}, {31'b0, id});
      chk({name, "_cout"},  {31'b0, bus.out_cout}, {31'b0, cout});
      chk({name, "_last"},  {31'b0, bus.out_last}, {31'b0, last});
      if (last) chk({name, "_ovf"}, {31'b0, bus.out_ovf}, {31'b0, ovf});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      drive_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;

      //            id    a             b             sub   last  sum           cout  ovf
      vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0});
`ifdef ADDER_SCHED_SUB_EN
      vecs.push_back('{1'b0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0});
`else
      vecs.push_back('{1'b0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'h0000000C, 1'b0, 1'b0});
`endif

      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_sum",   bus.out_sum, 32'd0);
      chk("rst_out_id",    {31'b0, bus.out_id}, 32'd0);
      chk("rst_out_last",  {31'b0, bus.out_last}, 32'd0);
      chk("rst_out_cout",  {31'b0, bus.out_cout}, 32'd0);
      chk("rst_out_ovf",   {31'b0, bus.out_ovf}, 32'd0);
      chk("rst_ready0",    {31'b0, bus.req0_ready}, 32'd0);
      chk("rst_ready1",    {31'b0, bus.req1_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         send_word(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].last);
         check_out($sformatf("vec%0d", i), vecs[i].id, vecs[i].sum,
                   vecs[i].cout, vecs[i].last, vecs[i].ovf);
      end
      @(posedge clk);
      @(negedge clk);
      chk("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);

      // Fair contention right after reset: strict 0,1,0,1 at one word per cycle.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      drive_req(1'b0, 1'b1, 32'h10, 32'h1, 1'b0, 1'b1);
      drive_req(1'b1, 1'b1, 32'h20, 32'h2, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rr_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("rr_id", {31'b0, bus.out_id}, (k % 2));
         chk("rr_sum", bus.out_sum, (k % 2) ? 32'h22 : 32'h11);
      end
      drive_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Lock hold: req0 opens a transaction then goes quiet; req1 must wait.
      send_word(1'b0, 32'h1, 32'h2, 1'b0, 1'b0);
      check_out("lock_w0", 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);
      drive_req(1'b1, 1'b1, 32'd100, 32'd1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("lock_ready1", {31'b0, bus.req1_ready}, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      chk("lock_out_valid", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b0;
      send_word(1'b0, 32'h5, 32'h6, 1'b0, 1'b1);
      check_out("lock_w1", 1'b0, 32'd11, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready0", {31'b0, bus.req0_ready}, 32'd0);
         chk("bp_ready1", {31'b0, bus.req1_ready}, 32'd0);
         chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("bp_sum", bus.out_sum, 32'd11);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready1", {31'b0, bus.req1_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check_out("bp_r1", 1'b1, 32'd101, 1'b0, 1'b1, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Reset in the middle of a two-word req0 transaction.
      send_word(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
      check_out("mid_w0", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      send_word(1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
      check_out("post_rst_r1", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      send_word(1'b0, 32'h1, 32'h2, 1'b0, 1'b1);
      check_out("post_rst_r0", 1'b0, 32'h3, 1'b0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/adder_sched.md
# adder_sched

Two-requester scheduler and multi-word sequencer for one shared `adder_n` instance. Each requester streams N-bit operand word pairs, least-significant word first, with a `last` flag. The block arbitrates round-robin at transaction granularity and chains the carry between words of a transaction. Results leave through a one-entry registered valid/ready output stage, so wide (k·N-bit) add/subtract runs on a single N-bit carry-lookahead adder.

## Interface
- `N`, 32, word width; passed to the internal `adder_n`.

One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1: requester 0 word valid.
- `req0_ready` out 1: requester 0 word accepted this cycle when both valid and ready are high.
- `req0_a`, `req0_b` in N: operand words.
- `req0_sub` in 1: subtract (a − b); sampled on the first word only.
- `req0_last` in 1: final (most-significant) word of the transaction.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`, `req1_last`: same meanings as requester 0.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: consumer accepts the result word.
- `out_sum` out N: result word.
- `out_id` out 1: requester that produced the word.
- `out_last` out 1: final word of the transaction.
- `out_cout` out 1: adder carry-out of this word; for subtract, 1 means no borrow.
- `out_ovf` out 1: signed overflow of this word; meaningful only when `out_last`=1.

## Operation
- **States**
  - IDLE: no owner.
  - LOCK0 / LOCK1: transaction open for that requester.
- **Slot free:** `slot_free = !out_valid || out_ready`.
- **Grant in IDLE (combinational)**
  - Exactly one requester valid: it is granted.
  - Both valid: requester selected by `rr_ptr` is granted.
  - No requester valid: no grant.
- **Ready:** `reqX_ready` = granted/owner is X && `slot_free`. The non-owner's ready is 0.
- **Accept, non-last word:** state moves to LOCKX; `carry_q` ← adder cout.
- **Accept, last word:**
  - State returns to IDLE.
  - `rr_ptr` ← ~X.
  - `carry_q` ← 0.
- **Adder inputs**
  - `a` = reqX_a.
  - `b` = reqX_b XOR {N{sub_eff}}.
  - `cin` = sub_eff on the first word of a transaction, `carry_q` on later words.
- **sub_eff:** reqX_sub on the first word; `sub_q` (latched at the first word) afterwards.
- **Overflow:** `out_ovf` = (a[N−1] == b_eff[N−1]) && (sum[N−1] != a[N−1]).
- **Lock hold:** in LOCKX, a deasserted reqX_valid holds the lock; the other requester stalls. No timeout.
- **One-word transactions:** first word with `last`=1 opens and closes the transaction in one accept.

## Timing
- **Reset values:**
  - All outputs are 0: `out_valid`, `out_sum`, `out_id`, `out_last`, `out_cout`, `out_ovf`, both readies.
  - State IDLE, `rr_ptr`=0, `carry_q`=0, `sub_q`=0.
- **Latency:** accepted word → `out_valid` on the next rising edge.
- **Throughput:** 1 word/cycle while `out_ready`=1.
- **Back-to-back transactions:** no bubble; the cycle after the last-word accept, IDLE arbitration grants again.
- **Backpressure:** `out_valid`=1 && `out_ready`=0 freezes all output fields and deasserts both readies.
- **Simultaneous output handoff:** `out_ready`=1 and a new accept in the same cycle replaces the output register with no gap.
- **Reset mid-transaction:**
  - Asynchronous clear: `out_valid` drops immediately.
  - In-flight word and open transaction are discarded; the lock is released.
  - Requester restarts from its first word.
- **Carry path:** the adder is purely combinational between input mux and output register. The critical path is mux → `adder_n` → register.

## Configuration
- `ADDER_SCHED_SUB_EN` defined:
  - Subtract supported as above.
- Undefined:
  - `reqX_sub` is ignored and `sub_eff`=0; no b inversion.
  - First-word cin is 0.
  - `sub_q` is not implemented.

## Test plan
- **Single add:** req0 word a=0xFFFFFFFF, b=0x00000001, last=1 → next cycle out_sum=0x00000000, out_cout=1, out_ovf=0, out_id=0, out_last=1.
- **64-bit add (2 words):** req1 words {a=0xFFFFFFFF, b=0x1}, then {a=0x0, b=0x0, last=1} → words 0x00000000 (cout=1) and 0x00000001 (cout=0, last=1).
- **Subtract (macro on):**
  - a=5, b=7 → out_sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1 → out_sum=0x7FFFFFFF, cout=1, ovf=1.
- **Fair contention:** after reset, both requesters hold valid with one-word transactions, out_ready=1 → out_id sequence 0,1,0,1…, one word per cycle.
- **Lock + backpressure:**
  - req0 sends word 1 of 2, then drops valid for 3 cycles while req1 stays valid → req1_ready=0 until req0's last word is accepted.
  - Holding out_ready=0 keeps out_sum stable and both readies 0.
- **Reset mid-transaction:** pulse rst_n low after req0's first of 2 words → out_valid=0 immediately. After release, req1's single word is granted first if req0 is idle; carry_q starts at 0.
